// File: rtl/dmem_responder_pkg.sv
// rtl/dmem_responder_pkg.sv - funct3 codes, opcodes and FSM encoding shared by the data-memory responder
package dmem_responder_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_S    = 7'b0100011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_responder_lsu_align.sv
// rtl/dmem_responder_lsu_align.sv - byte-lane steering, load extension and alignment checks
module lsu_align
  import dmem_responder_pkg::*;
(
  input  logic        wen_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] rword_i,
  input  logic [31:0] wdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        misalign_err_o,
  output logic        funct_err_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rword_i[{lane_i, 3'b000} +: 8];
  assign half_sel = rword_i[{lane_i[1], 4'b0000} +: 16];

  always_comb begin
    be_o           = 4'b0000;
    wdata_o        = 32'h0;
    rdata_o        = 32'h0;
    misalign_err_o = 1'b0;
    funct_err_o    = 1'b0;
    case (funct3_i)
      F3_B, F3_BU: begin
        be_o        = 4'b0001 << lane_i;
        wdata_o     = {4{wdata_i[7:0]}};
        rdata_o     = (funct3_i == F3_B) ? {{24{byte_sel[7]}}, byte_sel} : {24'h0, byte_sel};
        funct_err_o = wen_i && (funct3_i == F3_BU);
      end
      F3_H, F3_HU: begin
        be_o           = lane_i[1] ? 4'b1100 : 4'b0011;
        wdata_o        = {2{wdata_i[15:0]}};
        rdata_o        = (funct3_i == F3_H) ? {{16{half_sel[15]}}, half_sel} : {16'h0, half_sel};
        misalign_err_o = lane_i[0];
        funct_err_o    = wen_i && (funct3_i == F3_HU);
      end
      F3_W: begin
        be_o           = 4'b1111;
        wdata_o        = wdata_i;
        rdata_o        = rword_i;
        misalign_err_o = |lane_i;
      end
      default: funct_err_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - latency-programmable load/store responder with one outstanding request
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
  parameter int unsigned LATENCY    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [9:0]  req_funct,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned DEPTH    = 2 ** ADDR_WIDTH;
  localparam logic [32:0] SPAN     = 33'd4 << ADDR_WIDTH;
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        valid_q, valid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        wen_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q, wdata_q;
  logic        capture;

  logic [31:0] mem_q [DEPTH];

  // With LATENCY == 1 the access happens on the acceptance edge, so operands come straight from the request.
  logic                  acc_wen;
  logic [2:0]            acc_f3;
  logic [31:0]           acc_addr, acc_wdata, acc_offset;
  logic [ADDR_WIDTH-1:0] acc_index;
  logic                  out_of_range, acc_err, do_access, mem_we;
  logic [3:0]            be;
  logic [31:0]           wdata_sh, rdata_ext;
  logic                  misalign_err, funct_err;
  logic                  unused_funct;

  assign unused_funct = ^req_funct[9:3];

  assign acc_wen    = (state_q == IDLE) ? req_wen        : wen_q;
  assign acc_f3     = (state_q == IDLE) ? req_funct[2:0] : f3_q;
  assign acc_addr   = (state_q == IDLE) ? req_addr       : addr_q;
  assign acc_wdata  = (state_q == IDLE) ? req_wdata      : wdata_q;
  assign acc_offset = acc_addr - BASE_ADDR;
  assign acc_index  = acc_offset[ADDR_WIDTH+1:2];

  assign out_of_range = (acc_addr < BASE_ADDR) || ({1'b0, acc_offset} >= SPAN);
  assign acc_err      = out_of_range || misalign_err || funct_err;

  assign do_access = ((state_q == IDLE) && req_valid && (LATENCY == 1)) ||
                     ((state_q == WAIT) && (cnt_q == 4'd1));
  assign mem_we    = do_access && acc_wen && !acc_err;

  lsu_align u_align (
    .wen_i          (acc_wen),
    .funct3_i       (acc_f3),
    .lane_i         (acc_offset[1:0]),
    .rword_i        (mem_q[acc_index]),
    .wdata_i        (acc_wdata),
    .be_o           (be),
    .wdata_o        (wdata_sh),
    .rdata_o        (rdata_ext),
    .misalign_err_o (misalign_err),
    .funct_err_o    (funct_err)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          capture = 1'b1;
          cnt_d   = CNT_INIT;
          state_d = (LATENCY > 1) ? WAIT : RESP;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (do_access) begin
      valid_d = 1'b1;
      err_d   = acc_err;
      rdata_d = (acc_err || acc_wen) ? 32'h0 : rdata_ext;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      valid_q <= 1'b0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      wen_q   <= req_wen;
      f3_q    <= req_funct[2:0];
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[acc_index][8*b +: 8] <= wdata_sh[8*b +: 8];
      end
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = valid_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder at LATENCY 1 and 4
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam longint SPAN_BYTES = 4 * 4096;

  logic        clk = 1'b0;
  logic        rst        [2];
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_wen    [2];
  logic [9:0]  req_funct  [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [31:0] resp_rdata [2];
  logic        resp_err   [2];

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] mem_m [logic [32:0]];

  always #5 clk = ~clk;

  dmem_responder #(.LATENCY(1)) u_dut_l1 (
    .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_wen(req_wen[0]), .req_funct(req_funct[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]), .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0])
  );

  dmem_responder #(.LATENCY(4)) u_dut_l4 (
    .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_wen(req_wen[1]), .req_funct(req_funct[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]), .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1])
  );

  function automatic int lat(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: byte-addressed memory, access size from funct3, errors from range/alignment/legal codes.
  function automatic void model(input int d, input logic wen, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, output logic err, output logic [31:0] rd);
    longint off;
    int size;
    bit sgn, ok;
    logic [31:0] v;
    off = longint'(a) - longint'(BASE);
    size = 1; sgn = 0; ok = 1;
    case (f3)
      3'd0: begin size = 1; sgn = 1; end
      3'd1: begin size = 2; sgn = 1; end
      3'd2: size = 4;
      3'd4: begin size = 1; ok = !wen; end
      3'd5: begin size = 2; ok = !wen; end
      default: ok = 0;
    endcase
    err = !ok || (off < 0) || (off >= SPAN_BYTES) || ((off % size) != 0);
    rd = 32'h0;
    if (err) return;
    if (wen) begin
      for (int i = 0; i < size; i++) mem_m[{d[0], a + 32'(i)}] = wd[8*i +: 8];
    end else begin
      v = 32'h0;
      for (int i = 0; i < size; i++) v[8*i +: 8] = mem_m[{d[0], a + 32'(i)}];
      if (sgn) for (int j = 8 * size; j < 32; j++) v[j] = v[8*size-1];
      rd = v;
    end
  endfunction

  function automatic logic [31:0] gen_addr();
    int r;
    r = int'($urandom_range(0, 9));
    if (r < 7) return BASE + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
    if (r == 7) return BASE + 32'h3FFC + 32'($urandom_range(0, 3));
    if (r == 8) return BASE - 32'($urandom_range(1, 8));
    return BASE + 32'h4000 + 32'($urandom_range(0, 7));
  endfunction

  task automatic rand_fields(input int d);
    req_wen[d]   = 1'($urandom);
    req_funct[d] = 10'($urandom);
    req_addr[d]  = gen_addr();
    req_wdata[d] = $urandom;
  endtask

  task automatic xact(input int d, input logic wen, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, input int hold, output logic [31:0] rd, output logic er);
    logic        exp_err, hold_er;
    logic [31:0] exp_rd, hold_rd;
    int n;
    chk("idle_ready", 32'(req_ready[d]), 32'd1);
    req_valid[d] = 1'b1; req_wen[d] = wen; req_funct[d] = {7'($urandom), f3};
    req_addr[d] = a; req_wdata[d] = wd; resp_ready[d] = 1'b0;
    model(d, wen, f3, a, wd, exp_err, exp_rd);
    @(negedge clk);
    req_valid[d] = 1'b0; req_wen[d] = 1'bx; req_funct[d] = 'x; req_addr[d] = 'x; req_wdata[d] = 'x;
    n = 1;
    while (!resp_valid[d] && n < 40) begin
      chk("busy_ready", 32'(req_ready[d]), 32'd0);
      @(negedge clk);
      n++;
    end
    chk("latency", 32'(n), 32'(lat(d)));
    hold_rd = resp_rdata[d];
    hold_er = resp_err[d];
    repeat (hold) begin
      chk("hold_ready", 32'(req_ready[d]), 32'd0);
      @(negedge clk);
      chk("hold_valid", 32'(resp_valid[d]), 32'd1);
      chk("hold_rdata", resp_rdata[d], hold_rd);
      chk("hold_err", 32'(resp_err[d]), 32'(hold_er));
    end
    chk("rdata", resp_rdata[d], exp_rd);
    chk("err", 32'(resp_err[d]), 32'(exp_err));
    rd = resp_rdata[d];
    er = resp_err[d];
    resp_ready[d] = 1'b1;
    @(negedge clk);
    resp_ready[d] = 1'b0;
    chk("drop_valid", 32'(resp_valid[d]), 32'd0);
    chk("back_idle", 32'(req_ready[d]), 32'd1);
  endtask

  task automatic b2b(input int d);
    logic [31:0] q_rd [$];
    logic        q_er [$];
    int acc, got, last, cyc;
    bit accepted;
    logic e;
    logic [31:0] r;
    acc = 0; got = 0; last = -1; cyc = 0;
    resp_ready[d] = 1'b1;
    req_valid[d] = 1'b1;
    rand_fields(d);
    while (got < 8 && cyc < 200) begin
      accepted = 0;
      if (req_valid[d] && req_ready[d]) begin
        if (last >= 0) chk("b2b_spacing", 32'(cyc - last), 32'(lat(d) + 1));
        last = cyc;
        model(d, req_wen[d], req_funct[d][2:0], req_addr[d], req_wdata[d], e, r);
        q_er.push_back(e);
        q_rd.push_back(r);
        acc++;
        accepted = 1;
      end
      @(negedge clk);
      cyc++;
      if (accepted) begin
        if (acc == 8) req_valid[d] = 1'b0;
        else rand_fields(d);
      end
      if (resp_valid[d]) begin
        if (q_rd.size() == 0) chk("b2b_extra_resp", 32'd1, 32'd0);
        else begin
          chk("b2b_rdata", resp_rdata[d], q_rd.pop_front());
          chk("b2b_err", 32'(resp_err[d]), 32'(q_er.pop_front()));
          got++;
        end
      end
    end
    chk("b2b_count", 32'(got), 32'd8);
    repeat (4) begin
      @(negedge clk);
      chk("b2b_quiet", 32'(resp_valid[d]), 32'd0);
    end
    resp_ready[d] = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic er;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b0; req_valid[d] = 1'b0; req_wen[d] = 1'b0; req_funct[d] = '0;
      req_addr[d] = '0; req_wdata[d] = '0; resp_ready[d] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_valid", 32'(resp_valid[d]), 32'd0);
      chk("rst_ready", 32'(req_ready[d]), 32'd1);
      chk("rst_rdata", resp_rdata[d], 32'd0);
      chk("rst_err", 32'(resp_err[d]), 32'd0);
      rst[d] = 1'b1;
    end
    @(negedge clk);

    for (int d = 0; d < 2; d++) begin
      for (int w = 0; w < 17; w++) begin
        xact(d, 1'b1, F3_W, (w == 16) ? BASE + 32'h3FFC : BASE + 32'(w * 4), $urandom, 0, rd, er);
      end
    end

    xact(0, 1'b1, F3_W, 32'h8000_0010, 32'hDEAD_BEEF, 0, rd, er);
    xact(0, 1'b0, F3_W, 32'h8000_0010, 32'h0, 0, rd, er);
    chk("lw_deadbeef", rd, 32'hDEAD_BEEF);
    xact(0, 1'b1, F3_B, 32'h8000_0011, 32'h0000_0080, 0, rd, er);
    xact(0, 1'b0, F3_B, 32'h8000_0011, 32'h0, 0, rd, er);
    chk("lb_sext", rd, 32'hFFFF_FF80);
    xact(0, 1'b0, F3_BU, 32'h8000_0011, 32'h0, 0, rd, er);
    chk("lbu_zext", rd, 32'h0000_0080);
    xact(0, 1'b0, F3_W, 32'h8000_0010, 32'h0, 0, rd, er);
    chk("lw_after_sb", rd, 32'hDEAD_80EF);
    xact(0, 1'b0, F3_H, 32'h8000_0013, 32'h0, 0, rd, er);
    chk("lh_misalign_err", 32'(er), 32'd1);
    chk("lh_misalign_rdata", rd, 32'd0);
    xact(0, 1'b1, F3_W, 32'h7FFF_FFFC, 32'h1111_2222, 0, rd, er);
    chk("sw_range_err", 32'(er), 32'd1);
    xact(0, 1'b0, F3_W, 32'h8000_0010, 32'h0, 0, rd, er);
    chk("lw_unchanged", rd, 32'hDEAD_80EF);

    xact(1, 1'b1, F3_W, 32'h8000_0020, 32'hCAFE_F00D, 0, rd, er);
    xact(1, 1'b0, F3_W, 32'h8000_0020, 32'h0, 3, rd, er);
    chk("l4_lw_held", rd, 32'hCAFE_F00D);

    req_valid[1] = 1'b1; req_wen[1] = 1'b1; req_funct[1] = {7'd0, F3_W};
    req_addr[1] = 32'h8000_0020; req_wdata[1] = 32'h1234_5678;
    @(negedge clk);
    req_valid[1] = 1'b0;
    chk("rst_wait_busy", 32'(req_ready[1]), 32'd0);
    rst[1] = 1'b0;
    #1;
    chk("rst_wait_valid", 32'(resp_valid[1]), 32'd0);
    chk("rst_wait_idle", 32'(req_ready[1]), 32'd1);
    @(negedge clk);
    rst[1] = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("rst_no_resp", 32'(resp_valid[1]), 32'd0);
    end
    xact(1, 1'b0, F3_W, 32'h8000_0020, 32'h0, 0, rd, er);
    chk("rst_no_write", rd, 32'hCAFE_F00D);

    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 30; k++) begin
        xact(d, 1'($urandom), 3'($urandom), gen_addr(), $urandom, int'($urandom_range(0, 2)), rd, er);
      end
    end

    b2b(0);
    b2b(1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
